// File: rtl/iter_shift_pkg.sv
// Shared constants for the iterative shift/rotate unit.
// Opcode encoding and FSM state encoding.
package iter_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/iter_shift_unit_step.sv
// shift_step_cell: combinational one-position shift/rotate.
// Ports: din/op in; dout (next value), bout (bit moved out).
module shift_step_cell
    import iter_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout,
    output logic             bout
);

    always_comb begin
        dout = din;
        bout = 1'b0;
        unique case (op)
            OP_SLL: begin
                dout = {din[WIDTH-2:0], 1'b0};
                bout = din[WIDTH-1];
            end
            OP_SRL: begin
                dout = {1'b0, din[WIDTH-1:1]};
                bout = din[0];
            end
            OP_SRA: begin
                dout = {din[WIDTH-1], din[WIDTH-1:1]};
                bout = din[0];
            end
            OP_ROR: begin
                dout = {din[0], din[WIDTH-1:1]};
                bout = din[0];
            end
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA/ROR, one bit per clock.
// Ports: START/OPCODE/OPERAND/SHAMT in; RESULT/CARRY/ZERO/BUSY/DONE out.
module iter_shift_unit
    import iter_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [1:0]       OPCODE,
    input  logic [WIDTH-1:0] OPERAND,
    input  logic [SW-1:0]    SHAMT,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    logic [0:0]       state;
    logic [SW-1:0]    cnt;
    logic [SW-1:0]    eff;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_val;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             step_bit;

    // Rotates wrap; linear shifts saturate at WIDTH.
    always_comb begin
        if (OPCODE == OP_ROR)
            eff = SHAMT % SW'(WIDTH);
        else if (SHAMT > SW'(WIDTH))
            eff = SW'(WIDTH);
        else
            eff = SHAMT;
    end

    shift_step_cell #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (work),
        .op   (op_q),
        .dout (step_val),
        .bout (step_bit)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            work    <= '0;
            op_q    <= OP_SLL;
            carry_q <= 1'b0;
            RESULT  <= '0;
            CARRY   <= 1'b0;
            ZERO    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        work    <= OPERAND;
                        cnt     <= eff;
                        op_q    <= OPCODE;
                        carry_q <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        work    <= step_val;
                        carry_q <= step_bit;
                        cnt     <= cnt - SW'(1);
                    end else begin
                        // Outputs only move here, so they hold
                        // the previous result for the whole op.
                        RESULT <= work;
                        CARRY  <= carry_q;
                        ZERO   <= (work == '0);
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate unit for the ALU extension path.
- Executes SLL, SRL, SRA and ROR by a variable amount, one bit position per clock.
- Uses a START/BUSY/DONE handshake.
- Sits beside the ALU adder. The datapath controller issues long shifts here instead of chaining single-position combinational shifters.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- SW, $clog2(WIDTH)+1, localparam: SHAMT width, so SHAMT can express 0..WIDTH and above.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- START  input  1  request. Sampled only in IDLE.
- OPCODE  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- OPERAND  input  WIDTH  value to shift. Sampled with START.
- SHAMT  input  SW  shift amount. Sampled with START.
- RESULT  output  WIDTH  shifted value. Valid when DONE=1; held until the next accepted START.
- CARRY  output  1  last bit shifted or rotated out; 0 if the effective amount is 0. Held like RESULT.
- ZERO  output  1  RESULT==0. Held like RESULT.
- BUSY  output  1  operation in progress.
- DONE  output  1  single-cycle completion pulse.

Behaviour:
- Reset (RESETN=0, asynchronous): state=IDLE. RESULT, CARRY, ZERO, BUSY, DONE and internal counter are all 0. Reset mid-operation aborts with no DONE.
- Effective amount EFF:
  - ROR: SHAMT mod WIDTH.
  - SLL/SRL/SRA: min(SHAMT, WIDTH).
- States: IDLE, SHIFT.
- IDLE:
  - DONE=0 except for the completion cycle below.
  - On an edge with START=1: load the working register from OPERAND, load the counter with EFF, latch OPCODE, clear CARRY, enter SHIFT with BUSY=1.
  - START=0: stay in IDLE.
- SHIFT, edge with counter>0: shift the working register one position, CARRY gets the bit shifted out, counter decrements.
  - SLL: fill bit 0 with 0; out-bit is bit WIDTH-1.
  - SRL: fill bit WIDTH-1 with 0; out-bit is bit 0.
  - SRA: fill bit WIDTH-1 with the current bit WIDTH-1; out-bit is bit 0.
  - ROR: bit 0 moves into bit WIDTH-1; CARRY is that bit.
- SHIFT, edge with counter==0: go to IDLE, BUSY=0, DONE=1 for exactly one cycle. RESULT/ZERO update to the final value.
- Latency: START edge k → DONE high in the cycle after edge k+EFF+1. BUSY is high during cycles k+1..k+EFF+1.
- START during SHIFT is ignored; it is not queued.
- START in the DONE cycle (state is IDLE) is accepted: back-to-back operations with zero bubble.
- OPERAND/SHAMT/OPCODE changes during SHIFT have no effect.
- RESULT/CARRY/ZERO are driven from output registers, updated only at completion. While BUSY=1 they hold the previous operation's values.
- SRA saturated (amount ≥ WIDTH) gives all sign bits. SRL/SLL saturated gives 0, and CARRY = last bit out (bit WIDTH-1 for SLL, bit 0 was shifted... i.e. the original bit WIDTH-1 for SRL and the original bit 0 for SLL).

Decomposition:
- Package iter_shift_pkg:
  - opcode constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - state encoding ST_IDLE, ST_SHIFT.
- One sub-module, shift_step_cell: combinational one-position shifter.
  - Inputs: WIDTH value, OPCODE.
  - Outputs: next value and out-bit.
  - Generalises the existing single-position left/right shifters to WIDTH and adds arithmetic fill and rotate.
- Top level holds the FSM, counter and output registers.

Test Plan:
- SLL OPERAND=0x81, SHAMT=1 → RESULT=0x02, CARRY=1, ZERO=0. DONE one cycle after edge k+2; BUSY high exactly 2 cycles.
- SRA OPERAND=0x90, SHAMT=3 → RESULT=0xF2, CARRY=0. DONE after edge k+4.
- ROR OPERAND=0x01, SHAMT=9 (EFF=1) → RESULT=0x80, CARRY=1, latency 2 edges. SHAMT=8 → RESULT=0x01, CARRY=0, latency 1 edge.
- SRL OPERAND=0xFF, SHAMT=8 → RESULT=0x00, CARRY=1, ZERO=1, latency 9 edges. Repeat with SHAMT=12: identical result and latency.
- Start SLL 0x0F by 5; pulse START again with different data in cycle 2 (ignored). Assert RESETN=0 in cycle 3 → all outputs 0 immediately, no DONE. Release reset; new SRL 0x80 by 7 → 0x01, CARRY=0.
- SHAMT=0, SLL 0xA5 → RESULT=0xA5, CARRY=0 after 1 edge. START held high in the DONE cycle with ROR 0x03 by 1 → second DONE two edges later, RESULT=0x81, CARRY=1.
